// File: rtl/bit_serial_alu_seq.sv
// Runs a WIDTH-bit ALU op through an external 1-bit slice, LSB first, one bit per clock.
// Owns the operand/result shifters and inter-bit carry; returns the result plus NZCV flags.
//
// state | meaning
// IDLE  | waiting for start, slice pins held at 0
// RUN   | one bit per clock through the slice
// DONE  | result/flags valid for one cycle, can accept a back-to-back start
module bit_serial_alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op_control,
    input  logic [WIDTH-1:0] op_A,
    input  logic [WIDTH-1:0] op_B,
    output logic             slice_A,
    output logic             slice_B,
    output logic             slice_carry_in,
    output logic [2:0]       slice_control,
    input  logic             slice_result,
    input  logic             slice_carry_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [2:0]       r_ctrl;
    logic             r_carry;
    logic [CW-1:0]    r_count;

    logic             w_legal;
    logic             w_last;
    logic             w_arith;
    logic             w_run;
    logic [WIDTH-1:0] w_res_next;

    assign w_legal    = (op_control != 3'b001) && (op_control != 3'b111);
    assign w_run      = (r_state == S_RUN);
    assign w_last     = (r_count == CW'(WIDTH - 1));
    assign w_arith    = (r_ctrl[2:1] == 2'b01);
    assign w_res_next = {slice_result, r_res_sh[WIDTH-1:1]};

    // Slice pins come only from registers, gated to 0 outside RUN
    assign busy           = w_run;
    assign slice_A        = w_run & r_a_sh[0];
    assign slice_B        = w_run & r_b_sh[0];
    assign slice_carry_in = w_run & r_carry;
    assign slice_control  = w_run ? r_ctrl : 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_ctrl   <= 3'b000;
            r_carry  <= 1'b0;
            r_count  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            flag_n   <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (start) begin
                        if (w_legal) begin
                            r_a_sh  <= op_A;
                            r_b_sh  <= op_B;
                            r_ctrl  <= op_control;
                            // subtract is A + ~B + 1, so the initial carry is the op LSB
                            r_carry <= op_control[0];
                            r_count <= '0;
                            r_state <= S_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_res_sh <= w_res_next;
                    r_carry  <= slice_carry_out;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_count  <= r_count + CW'(1);
                    if (w_last) begin
                        result  <= w_res_next;
                        flag_n  <= slice_result;
                        flag_z  <= (w_res_next == '0);
                        // r_carry here is the carry into the MSB
                        flag_c  <= w_arith & slice_carry_out;
                        flag_v  <= w_arith & (r_carry ^ slice_carry_out);
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Bench for bit_serial_alu_seq (WIDTH=8) with a behavioural 1-bit slice, an arithmetic
// reference model and a queue-based scoreboard checked by an independent monitor.
module tb_bit_serial_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op_control;
    logic [W-1:0] op_A, op_B;
    logic         slice_A, slice_B, slice_carry_in;
    logic [2:0]   slice_control;
    logic         slice_result, slice_carry_out;
    logic         busy, done, err;
    logic [W-1:0] result;
    logic         flag_n, flag_z, flag_c, flag_v;

    bit_serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op_control(op_control),
        .op_A(op_A), .op_B(op_B),
        .slice_A(slice_A), .slice_B(slice_B), .slice_carry_in(slice_carry_in),
        .slice_control(slice_control),
        .slice_result(slice_result), .slice_carry_out(slice_carry_out),
        .busy(busy), .done(done), .err(err), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    // behavioural 1-bit ALU slice
    logic [1:0] s_sum;
    always_comb begin
        s_sum           = 2'b00;
        slice_result    = 1'b0;
        slice_carry_out = 1'b0;
        case (slice_control)
            3'b000: slice_result = slice_B;
            3'b010: begin
                s_sum = {1'b0, slice_A} + {1'b0, slice_B} + {1'b0, slice_carry_in};
                slice_result    = s_sum[0];
                slice_carry_out = s_sum[1];
            end
            3'b011: begin
                s_sum = {1'b0, slice_A} + {1'b0, ~slice_B} + {1'b0, slice_carry_in};
                slice_result    = s_sum[0];
                slice_carry_out = s_sum[1];
            end
            3'b100: slice_result = slice_A & slice_B;
            3'b101: slice_result = slice_A | slice_B;
            3'b110: slice_result = slice_A ^ slice_B;
            default: ;
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   nzcv;
        logic [2:0]   op;
        logic [W-1:0] a;
        int           acc;
    } exp_t;

    exp_t         q[$];
    int           err_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           run_mon = 1'b0;
    logic [W-1:0] last_res = '0;
    logic [3:0]   last_nzcv = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    // reference model: plain 9-bit arithmetic on whole words
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int acc);
        exp_t        e;
        logic [W:0]  full;
        logic        c, v;
        full = '0;
        c = 1'b0;
        v = 1'b0;
        e.res = '0;
        case (op)
            3'b000: e.res = b;
            3'b010: begin
                full  = {1'b0, a} + {1'b0, b};
                e.res = full[W-1:0];
                c     = full[W];
                v     = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b011: begin
                full  = {1'b0, a} + {1'b0, ~b} + 9'd1;
                e.res = full[W-1:0];
                c     = full[W];
                v     = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b100: e.res = a & b;
            3'b101: e.res = a | b;
            3'b110: e.res = a ^ b;
            default: ;
        endcase
        e.nzcv = {e.res[W-1], (e.res == '0), c, v};
        e.op   = op;
        e.a    = a;
        e.acc  = acc;
        return e;
    endfunction

    // monitor: samples on the falling edge, fully decoupled from stimulus
    always @(negedge clk) begin
        if (run_mon) begin
            if (q.size() > 0) begin
                int rel;
                rel = cyc - q[0].acc;
                chk("busy", busy, (rel < W) ? 32'd1 : 32'd0);
                if (rel < W) begin
                    chk("early_done", done, 0);
                    chk("slice_ctl_run", slice_control, q[0].op);
                    chk("slice_a_bit", slice_A, q[0].a[rel]);
                end else begin
                    chk("done", done, 1);
                    chk("slice_idle_done", {slice_A, slice_B, slice_carry_in, slice_control}, 0);
                    if (done) begin
                        chk("result", result, q[0].res);
                        chk("nzcv", {flag_n, flag_z, flag_c, flag_v}, q[0].nzcv);
                        last_res  = q[0].res;
                        last_nzcv = q[0].nzcv;
                    end
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("unexpected_done", done, 0);
                chk("slice_idle", {slice_A, slice_B, slice_carry_in, slice_control}, 0);
            end
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                chk("err_pulse", err, 1);
                chk("err_busy", busy, 0);
                chk("err_hold_result", result, last_res);
                chk("err_hold_nzcv", {flag_n, flag_z, flag_c, flag_v}, last_nzcv);
                void'(err_q.pop_front());
            end else begin
                chk("spurious_err", err, 0);
            end
        end
    end

    // called in the posedge+2 phase; returns in the posedge+2 phase after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        while (busy && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        if (busy) fail_now("ready_wait");
        start = 1'b1; op_control = op; op_A = a; op_B = b;
        @(posedge clk); #2;
        start = 1'b0;
        op_control = 3'($urandom); op_A = W'($urandom); op_B = W'($urandom);
        if (op != 3'b001 && op != 3'b111) q.push_back(model(op, a, b, cyc));
        else err_q.push_back(cyc);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() > 0 || err_q.size() > 0) && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        if (q.size() > 0 || err_q.size() > 0) begin
            fail_now("drain");
            q.delete();
            err_q.delete();
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {busy, done, err, result, flag_n, flag_z, flag_c, flag_v,
                   slice_A, slice_B, slice_carry_in, slice_control}, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_control = 3'b000; op_A = '0; op_B = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        chk_all_zero("reset_state");
        run_mon = 1'b1;
        @(posedge clk); #2;

        issue(3'b010, 8'h7F, 8'h01);
        drain();

        issue(3'b011, 8'h05, 8'h05);
        issue(3'b011, 8'h00, 8'h01);
        drain();

        issue(3'b100, 8'hF0, 8'h3C);
        issue(3'b101, 8'hF0, 8'h3C);
        issue(3'b110, 8'hF0, 8'h3C);
        issue(3'b000, 8'hF0, 8'h3C);
        drain();

        issue(3'b111, 8'h11, 8'h22);
        issue(3'b001, 8'h33, 8'h44);
        repeat (3) begin @(posedge clk); #2; end
        drain();

        // abort mid-op at bit 4
        issue(3'b010, 8'hFF, 8'h01);
        repeat (4) begin @(posedge clk); #2; end
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        q.delete();
        last_res = '0;
        last_nzcv = '0;
        chk_all_zero("reset_abort");
        issue(3'b010, 8'h01, 8'h01);
        drain();

        // start pulse while RUN must be ignored
        issue(3'b010, 8'h12, 8'h34);
        repeat (3) begin @(posedge clk); #2; end
        start = 1'b1; op_control = 3'b110; op_A = 8'hFF; op_B = 8'h00;
        @(posedge clk); #2;
        start = 1'b0;
        drain();

        // start and reset together: reset wins
        start = 1'b1; reset = 1'b1; op_control = 3'b010; op_A = 8'h0F; op_B = 8'h0F;
        @(posedge clk); #2;
        start = 1'b0; reset = 1'b0;
        last_res = '0;
        last_nzcv = '0;
        chk_all_zero("start_with_reset");
        repeat (2) begin @(posedge clk); #2; end

        for (int i = 0; i < 30; i++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 12)) begin @(posedge clk); #2; end
            end
        end
        drain();
        repeat (3) begin @(posedge clk); #2; end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
